l1_mem_arbiter: RTL and testbench

- Sits between the core-side mem_bus (instruction and data ports) and a single-ported backing memory with a req/ack handshake.
- Serializes instruction-fetch and load/store requests onto that one port using round-robin arbitration.
- Generates imem_wait/dmem_wait back to the core and registers returned read data.
- Includes an ack-timeout watchdog that flags a hung memory.

---
 rtl/l1_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_l1_mem_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter serializing instruction fetches and data accesses onto one
// req/ack backing-memory port, with an ack-timeout watchdog.
//
// state  | meaning
// IDLE   | no access in flight, arbitrate pending requests
// BUSY_I | fetch issued to memory, waiting for ack or timeout
// BUSY_D | data access issued to memory, waiting for ack or timeout
// RESP_I | fetch data presented, imem_wait low for one cycle
// RESP_D | data access complete, dmem_wait low for one cycle
module l1_mem_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_instn,
  output logic        imem_wait,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wd,
  input  logic [3:0]  dmem_mask,
  output logic [31:0] dmem_rd,
  output logic        dmem_wait,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t        state, state_nxt;
  logic          last_d, last_d_nxt;
  logic [31:0]   ihold, dhold;
  logic [CW-1:0] tcnt;
  logic          busy, tc_hit;
  logic          arb_en, cand_i, cand_d;

  assign busy   = (state == BUSY_I) || (state == BUSY_D);
  assign tc_hit = busy && (tcnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    arb_en     = 1'b0;
    cand_i     = 1'b0;
    cand_d     = 1'b0;
    case (state)
      IDLE:   begin arb_en = 1'b1; cand_i = imem_req; cand_d = dmem_req; end
      RESP_I: begin arb_en = 1'b1; cand_d = dmem_req; end
      RESP_D: begin arb_en = 1'b1; cand_i = imem_req; end
      BUSY_I: if (mem_ack || tc_hit) state_nxt = RESP_I;
      BUSY_D: if (mem_ack || tc_hit) state_nxt = RESP_D;
      default: state_nxt = IDLE;
    endcase
    // On a tie the port that did not win last time gets the grant.
    if (arb_en) begin
      if (cand_i && (!cand_d || last_d)) begin
        state_nxt  = BUSY_I;
        last_d_nxt = 1'b0;
      end else if (cand_d) begin
        state_nxt  = BUSY_D;
        last_d_nxt = 1'b1;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req <= 1'b0;
      tcnt    <= '0;
    end else begin
      mem_req <= (state_nxt == BUSY_I) || (state_nxt == BUSY_D);
      if (!busy)
        tcnt <= '0;
      else if (!mem_ack)
        tcnt <= tcnt + 1'b1;
    end
  end

  // A real ack always takes priority over a coincident timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ihold       <= '0;
      dhold       <= '0;
      timeout_err <= 1'b0;
    end else if (state == BUSY_I) begin
      if (mem_ack) begin
        ihold <= mem_rdata;
      end else if (tc_hit) begin
        ihold       <= ERR_DATA;
        timeout_err <= 1'b1;
      end
    end else if (state == BUSY_D) begin
      if (mem_ack) begin
        if (!dmem_we) dhold <= mem_rdata;
      end else if (tc_hit) begin
        if (!dmem_we) dhold <= ERR_DATA;
        timeout_err <= 1'b1;
      end
    end
  end

  assign mem_we   = (state == BUSY_D) && dmem_we;
  assign mem_addr = ((state == BUSY_I) ? imem_addr : dmem_addr) & 32'hFFFF_FFFC;
  assign mem_wd   = dmem_wd;
  assign mem_mask = (state == BUSY_I) ? 4'b1111 : dmem_mask;

  assign imem_wait  = imem_req && (state != RESP_I);
  assign dmem_wait  = dmem_req && (state != RESP_D);
  assign imem_instn = imem_req ? ihold : 32'h0;
  assign dmem_rd    = dmem_req ? dhold : 32'h0;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomized bench: well-behaved core ports and an array-backed memory with random
// ack latency (including never), checked against a transaction-level model.
module tb_l1_mem_arbiter;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, dmem_req, dmem_we, mem_req, mem_we, mem_ack;
  logic        imem_wait, dmem_wait, timeout_err;
  logic [31:0] imem_addr, imem_instn, dmem_addr, dmem_wd, dmem_rd;
  logic [31:0] mem_addr, mem_wd, mem_rdata;
  logic [3:0]  dmem_mask, mem_mask;

  l1_mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_instn(imem_instn), .imem_wait(imem_wait),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wd(dmem_wd),
    .dmem_mask(dmem_mask), .dmem_rd(dmem_rd), .dmem_wait(dmem_wait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference state: memory contents, outstanding core requests, in-flight access.
  logic [31:0] mem_m [256];
  bit          i_act, d_act, d_we;
  logic [31:0] i_addr, d_addr, d_wd, dhold_m, resp_data;
  logic [3:0]  d_mask;
  bit          pend_i, pend_d, last_is_d, terr_m;
  bit          acc_act, acc_d, resp_v, resp_d, force_both, did_reset;
  int          acc_cnt, acc_lat;

  task automatic model_init();
    i_act = 0; d_act = 0; pend_i = 0; pend_d = 0;
    last_is_d = 1; terr_m = 0; dhold_m = '0;
    acc_act = 0; resp_v = 0; force_both = 0;
    imem_req = 0; dmem_req = 0; dmem_we = 0; mem_ack = 0;
    imem_addr = '0; dmem_addr = '0; dmem_wd = '0; dmem_mask = '0; mem_rdata = '0;
  endtask

  task automatic step(input int p_new);
    bit          np_i, np_d, ended;
    logic [31:0] a, exp_addr;
    int          idx;
    mem_ack = 0;
    mem_rdata = $urandom();
    if (!i_act && (force_both || $urandom_range(0, 99) < p_new)) begin
      i_act = 1; i_addr = $urandom();
    end
    if (!d_act && (force_both || $urandom_range(0, 99) < p_new)) begin
      d_act = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom();
      d_wd = $urandom(); d_mask = 4'($urandom_range(0, 15));
    end
    force_both = 0;
    imem_req = i_act; imem_addr = i_addr;
    dmem_req = d_act; dmem_addr = d_addr; dmem_we = d_we; dmem_wd = d_wd; dmem_mask = d_mask;
    #1;
    chk("timeout_err", timeout_err, terr_m);
    if (!i_act) chk("imem_instn_noreq", imem_instn, 0);
    if (!d_act) chk("dmem_rd_noreq", dmem_rd, 0);
    np_i = 0; np_d = 0;
    if (resp_v) begin
      chk("mem_req_resp", mem_req, 0);
      if (!resp_d) begin
        chk("imem_wait_resp", imem_wait, 0);
        chk("dmem_wait_other", dmem_wait, d_act);
        chk("imem_instn", imem_instn, resp_data);
        i_act = 0; np_d = d_act;
      end else begin
        chk("dmem_wait_resp", dmem_wait, 0);
        chk("imem_wait_other", imem_wait, i_act);
        chk("dmem_rd", dmem_rd, resp_data);
        d_act = 0; np_i = i_act;
      end
      resp_v = 0;
      if ($urandom_range(0, 7) == 0) mem_ack = 1;
    end else begin
      if (!acc_act && (pend_i || pend_d)) begin
        acc_d = pend_d && (!pend_i || !last_is_d);
        last_is_d = acc_d;
        acc_act = 1; acc_cnt = 0;
        acc_lat = $urandom_range(0, TO);
      end
      if (acc_act) begin
        chk("mem_req_busy", mem_req, 1);
        chk("imem_wait_busy", imem_wait, i_act);
        chk("dmem_wait_busy", dmem_wait, d_act);
        a = acc_d ? d_addr : i_addr;
        exp_addr = {a[31:2], 2'b00};
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_we", mem_we, acc_d && d_we);
        chk("mem_mask", mem_mask, acc_d ? d_mask : 4'hF);
        if (acc_d && d_we) chk("mem_wd", mem_wd, d_wd);
        idx = int'(a[9:2]);
        ended = 0;
        if (acc_cnt == acc_lat) begin
          mem_ack = 1; ended = 1;
          if (acc_d && d_we) begin
            resp_data = dhold_m;
            for (int b = 0; b < 4; b++)
              if (d_mask[b]) mem_m[idx][8*b +: 8] = d_wd[8*b +: 8];
          end else begin
            mem_rdata = mem_m[idx];
            resp_data = mem_m[idx];
          end
        end else if (acc_cnt == TO - 1) begin
          ended = 1; terr_m = 1;
          resp_data = (acc_d && d_we) ? dhold_m : ERR;
        end
        if (ended) begin
          if (acc_d && !d_we) dhold_m = resp_data;
          acc_act = 0; resp_v = 1; resp_d = acc_d;
        end else begin
          acc_cnt++;
        end
      end else begin
        chk("mem_req_idle", mem_req, 0);
        chk("imem_wait_idle", imem_wait, i_act);
        chk("dmem_wait_idle", dmem_wait, d_act);
        np_i = i_act; np_d = d_act;
        if ($urandom_range(0, 7) == 0) mem_ack = 1;
      end
    end
    pend_i = np_i; pend_d = np_d;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = $urandom();
    model_init();
    did_reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_imem_wait", imem_wait, 0);
    chk("rst_dmem_wait", dmem_wait, 0);
    #3 rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      step(cyc < 1000 ? 90 : (cyc < 2000 ? 50 : 20));
      if (cyc > 1200 && !did_reset && acc_act && acc_d) begin
        did_reset = 1;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        model_init();
        #3 rst_n = 1'b1;
        force_both = 1;
      end
    end
    chk("reset_applied", did_reset, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
